core_datapath_p: RTL and testbench
==================================

Name: core_datapath_p

Overview:
- Parametrised successor to the fixed 8-bit, 14-register core datapath. Provides a general register bank with per-register write/increment/clear, a bus source mux, an accumulator ALU, a pointer-to-data-address mux and two equality-compare flags.
- Adds a memory-wait stall handshake so the core's control unit can run against slow shared memory in the multicore build.
- Sits between the control unit, the instruction/data memories and the inter-core bus.

Parameters:
- DATA_W, 8, register/bus/ALU width.
- NREG, 12, number of general registers (reg[0..NREG-1]).
- SEL_W, 4, bus_sel width; must satisfy 2^SEL_W >= NREG+2.
- PTR_N, 4, number of pointer registers (reg[0..PTR_N-1]) feeding the data address mux.
- PSEL_W, 2, ptr_sel width; 2^PSEL_W >= PTR_N.
- Z1_A, 8 / Z1_B, 9, register indices compared for z1.
- Z2_A, 10 / Z2_B, 11, register indices compared for z2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_n  in  1  asynchronous active-low reset.
- wen  in  NREG  per-register load from the bus.
- inc  in  NREG  per-register increment.
- clr  in  NREG  per-register synchronous clear.
- bus_sel  in  SEL_W  bus source select.
- alu_op  in  3  accumulator operation.
- ac_wen  in  1  accumulator update enable.
- ptr_sel  in  PSEL_W  selects the data address pointer.
- mem_rdata  in  DATA_W  data memory read data.
- mem_valid  in  1  mem_rdata valid this cycle.
- bus  out  DATA_W  current bus value (also the memory write data).
- d_addr  out  DATA_W  reg[ptr_sel]; 0 if ptr_sel >= PTR_N.
- ac  out  DATA_W  accumulator.
- z1  out  1  reg[Z1_A] == reg[Z1_B].
- z2  out  1  reg[Z2_A] == reg[Z2_B].
- stall  out  1  datapath frozen this cycle.

Behaviour:
- Reset (RST_n low, asynchronous): all reg[i] = 0, ac = 0. Consequently z1 = z2 = 1, stall = 0 and d_addr = 0. Reset asserted mid-stall clears everything; the first edge after release operates normally.
- Bus mux (combinational):
  - bus_sel 0: mem_rdata.
  - bus_sel 1: ac.
  - bus_sel 2..NREG+1: reg[bus_sel-2].
  - Any other value: 0.
- Stall (combinational): stall = (bus_sel == 0) && (|wen || ac_wen) && !mem_valid.
  - While stall = 1, no register and no accumulator changes, including inc and clr.
  - Control holds its inputs stable until stall drops.
  - The update happens on the first edge with mem_valid = 1; there is no added latency.
- Per-register update on each non-stalled edge, priority clr > wen > inc:
  - clr: reg <= 0.
  - wen: reg <= bus.
  - inc: reg <= reg + 1, wrapping modulo 2^DATA_W (all-ones becomes 0).
- Several registers may be written in the same cycle; all take the same bus value.
- A register that is both the bus source and written with wen reloads its own old value. Combined with inc, wen wins.
- Accumulator: updates only when ac_wen = 1 and not stalled. All results are truncated to DATA_W and carries are discarded.
  - op 0: ac <= bus.
  - op 1: ac <= ac + bus.
  - op 2: ac <= ac - bus (two's complement wrap).
  - op 3: ac <= low DATA_W bits of ac * bus.
  - op 4: ac <= ac & bus.
  - op 5: ac <= ac | bus.
  - op 6: ac <= ac + 1.
  - op 7: ac <= 0.
- bus_sel = 1 with ac_wen uses the pre-edge ac; the update is single-cycle.
- z1 and z2 are combinational on the current register values, so they reflect updates one cycle after the edge that writes the compared registers.
- d_addr is combinational on current register values; a pointer incremented at edge N gives the new address during cycle N+1.
- Latency: every write, increment, clear and ALU operation completes in one clock when not stalled.
- Out-of-range parameter indices (Z*_x >= NREG, PTR_N > NREG) are an elaboration error; implement with a generate-time check.

Test Plan:
- Reset: assert RST_n low asynchronously mid-cycle with reg[3] = 0x55 and ac = 0x12 -> both read 0 immediately, z1 = z2 = 1, stall = 0.
- Load/increment/wrap: bus_sel = 2+3, reg[3] = 0xFE; assert inc[3] for 2 cycles -> 0xFF then 0x00. Then assert clr[3], wen[3] and inc[3] together -> reg[3] = 0.
- Memory stall: bus_sel = 0, wen[5] = 1, mem_valid low for 3 cycles with inc[0] also asserted -> stall = 1 for 3 cycles, reg[5] and reg[0] unchanged. Raise mem_valid with mem_rdata = 0xA7 -> reg[5] = 0xA7 and reg[0] incremented once on that edge.
- ALU sweep: ac = 0x0C, bus from reg = 0x15. Run ops 1,2,3,4,5 in turn, reloading ac = 0x0C each time -> 0x21, 0xF7, 0xFC, 0x04, 0x1D. Op 6 on 0xFF -> 0x00.
- Compare flags: write reg[10] = 7 and reg[11] = 5, then inc reg[11] twice -> z2 = 0, 0, then 1 in the cycle after the second increment. Next, write reg[8] = 3 -> z1 = 0.
- Pointer mux: reg[0..3] = 0x10, 0x20, 0x30, 0x40; sweep ptr_sel 0..3 -> d_addr follows each value. inc[2] -> d_addr = 0x31 on the next cycle with ptr_sel = 2.

Source files
------------

// File: rtl/core_datapath_p_if.sv
// Control/memory-side signal bundle of core_datapath_p. The control unit
// and memory drive the master side; the datapath sits on the slave side.
interface core_datapath_p_if #(
  parameter int DATA_W = 8,
  parameter int NREG   = 12,
  parameter int SEL_W  = 4,
  parameter int PSEL_W = 2
);
  logic [NREG-1:0]   wen;
  logic [NREG-1:0]   inc;
  logic [NREG-1:0]   clr;
  logic [SEL_W-1:0]  bus_sel;
  logic [2:0]        alu_op;
  logic              ac_wen;
  logic [PSEL_W-1:0] ptr_sel;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] ac;
  logic              z1;
  logic              z2;
  logic              stall;

  modport master (
    output wen, inc, clr, bus_sel, alu_op, ac_wen, ptr_sel, mem_rdata, mem_valid,
    input  bus, d_addr, ac, z1, z2, stall
  );

  modport slave (
    input  wen, inc, clr, bus_sel, alu_op, ac_wen, ptr_sel, mem_rdata, mem_valid,
    output bus, d_addr, ac, z1, z2, stall
  );
endinterface

// File: rtl/core_datapath_p.sv
// Parametrised core datapath: register bank, bus mux, accumulator ALU,
// pointer address mux, equality flags and a memory-wait stall.
module core_datapath_p #(
  parameter int DATA_W = 8,
  parameter int NREG   = 12,
  parameter int SEL_W  = 4,
  parameter int PTR_N  = 4,
  parameter int PSEL_W = 2,
  parameter int Z1_A   = 8,
  parameter int Z1_B   = 9,
  parameter int Z2_A   = 10,
  parameter int Z2_B   = 11
) (
  input logic              CLK,
  input logic              RST_n,
  core_datapath_p_if.slave dp
);

  if (Z1_A >= NREG || Z1_B >= NREG || Z2_A >= NREG || Z2_B >= NREG ||
      PTR_N > NREG || PTR_N > (1 << PSEL_W) || (1 << SEL_W) < NREG + 2) begin : g_param_err
    $error("core_datapath_p: register index or select width parameter out of range");
  end

  logic [DATA_W-1:0] gpr [NREG];
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] bus_val;
  logic [DATA_W-1:0] addr_val;
  logic              stall_now;

  // Accumulator operation; every result wraps to DATA_W bits.
  function automatic logic [DATA_W-1:0] alu_result(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      3'd0: r = b;
      3'd1: r = a + b;
      3'd2: r = a - b;
      3'd3: r = a * b;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a + DATA_W'(1);
      3'd7: r = '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    bus_val = '0;
    if (dp.bus_sel == '0) begin
      bus_val = dp.mem_rdata;
    end else if (dp.bus_sel == SEL_W'(1)) begin
      bus_val = acc;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (dp.bus_sel == SEL_W'(i + 2)) bus_val = gpr[i];
      end
    end
  end

  always_comb begin
    addr_val = '0;
    for (int i = 0; i < PTR_N; i++) begin
      if (dp.ptr_sel == PSEL_W'(i)) addr_val = gpr[i];
    end
  end

  // Freeze only when something actually consumes memory data that is not ready yet.
  assign stall_now = (dp.bus_sel == '0) && ((|dp.wen) || dp.ac_wen) && !dp.mem_valid;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (!stall_now) begin
      for (int i = 0; i < NREG; i++) begin
        if (dp.clr[i])      gpr[i] <= '0;
        else if (dp.wen[i]) gpr[i] <= bus_val;
        else if (dp.inc[i]) gpr[i] <= gpr[i] + DATA_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      acc <= '0;
    end else if (!stall_now && dp.ac_wen) begin
      acc <= alu_result(dp.alu_op, acc, bus_val);
    end
  end

  assign dp.bus    = bus_val;
  assign dp.d_addr = addr_val;
  assign dp.ac     = acc;
  assign dp.z1     = (gpr[Z1_A] == gpr[Z1_B]);
  assign dp.z2     = (gpr[Z2_A] == gpr[Z2_B]);
  assign dp.stall  = stall_now;

endmodule

// File: tb/tb_core_datapath_p.sv
// Self-checking bench for core_datapath_p: directed scenarios plus random
// control traffic compared against an arithmetic model of the datapath.
module tb_core_datapath_p;
  localparam int DATA_W = 8;
  localparam int NREG   = 12;
  localparam int SEL_W  = 4;
  localparam int PTR_N  = 4;
  localparam int PSEL_W = 2;
  localparam int MASK   = (1 << DATA_W) - 1;

  logic CLK = 1'b0;
  logic RST_n;
  always #5 CLK = ~CLK;

  core_datapath_p_if #(.DATA_W(DATA_W), .NREG(NREG), .SEL_W(SEL_W), .PSEL_W(PSEL_W)) dp ();

  core_datapath_p #(
    .DATA_W(DATA_W), .NREG(NREG), .SEL_W(SEL_W), .PTR_N(PTR_N), .PSEL_W(PSEL_W),
    .Z1_A(8), .Z1_B(9), .Z2_A(10), .Z2_B(11)
  ) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .dp   (dp)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int m_reg [NREG];
  int m_ac;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_bus();
    int s;
    s = int'(dp.bus_sel);
    if (s == 0) return int'(dp.mem_rdata);
    if (s == 1) return m_ac;
    if (s - 2 < NREG) return m_reg[s - 2];
    return 0;
  endfunction

  function automatic bit m_stall();
    return (dp.bus_sel == 0) && ((dp.wen != 0) || dp.ac_wen) && !dp.mem_valid;
  endfunction

  function automatic int m_alu(input int op, input int a, input int b);
    case (op)
      0: return b;
      1: return (a + b) & MASK;
      2: return (a - b) & MASK;
      3: return (a * b) & MASK;
      4: return a & b;
      5: return a | b;
      6: return (a + 1) & MASK;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = 0;
    m_ac = 0;
  endtask

  task automatic check_outputs();
    int pa;
    #1;
    pa = int'(dp.ptr_sel);
    chk("bus", 32'(dp.bus), m_bus());
    chk("stall", 32'(dp.stall), 32'(m_stall()));
    chk("ac", 32'(dp.ac), m_ac);
    chk("d_addr", 32'(dp.d_addr), (pa < PTR_N) ? m_reg[pa] : 0);
    chk("z1", 32'(dp.z1), 32'(m_reg[8] == m_reg[9]));
    chk("z2", 32'(dp.z2), 32'(m_reg[10] == m_reg[11]));
  endtask

  // Applies one rising edge with the current inputs; starts and ends in the low phase.
  task automatic cycle();
    int b;
    bit st;
    int nr [NREG];
    int na;
    b  = m_bus();
    st = m_stall();
    nr = m_reg;
    na = m_ac;
    if (!st) begin
      for (int i = 0; i < NREG; i++) begin
        if (dp.clr[i])      nr[i] = 0;
        else if (dp.wen[i]) nr[i] = b;
        else if (dp.inc[i]) nr[i] = (m_reg[i] + 1) & MASK;
      end
      if (dp.ac_wen) na = m_alu(int'(dp.alu_op), m_ac, b);
    end
    @(posedge CLK);
    m_reg = nr;
    m_ac  = na;
    @(negedge CLK);
  endtask

  task automatic set_idle();
    dp.wen = '0; dp.inc = '0; dp.clr = '0;
    dp.bus_sel = SEL_W'(15); dp.alu_op = 3'd0; dp.ac_wen = 1'b0;
    dp.ptr_sel = '0; dp.mem_rdata = '0; dp.mem_valid = 1'b1;
  endtask

  task automatic load_reg(input int idx, input int val);
    set_idle();
    dp.bus_sel = '0; dp.mem_rdata = DATA_W'(val); dp.wen[idx] = 1'b1;
    cycle();
    set_idle();
  endtask

  task automatic load_ac(input int val);
    set_idle();
    dp.bus_sel = '0; dp.mem_rdata = DATA_W'(val); dp.ac_wen = 1'b1; dp.alu_op = 3'd0;
    cycle();
    set_idle();
  endtask

  // Reads back every bus source and pointer with no enables active.
  task automatic dump_check();
    set_idle();
    for (int s = 0; s < 16; s++) begin
      dp.bus_sel = SEL_W'(s);
      dp.mem_rdata = DATA_W'($urandom);
      #1 chk($sformatf("dump_bus%0d", s), 32'(dp.bus), m_bus());
    end
    for (int p = 0; p < PTR_N; p++) begin
      dp.ptr_sel = PSEL_W'(p);
      #1 chk($sformatf("dump_ptr%0d", p), 32'(dp.d_addr), m_reg[p]);
    end
    set_idle();
    @(negedge CLK);
  endtask

  int alu_exp [5] = '{8'h21, 8'hF7, 8'hFC, 8'h04, 8'h1D};
  bit held;

  initial begin
    RST_n = 1'b0;
    set_idle();
    m_reset();
    repeat (2) @(negedge CLK);
    check_outputs();
    chk("rst_z1", 32'(dp.z1), 32'd1);
    chk("rst_z2", 32'(dp.z2), 32'd1);
    RST_n = 1'b1;
    @(negedge CLK);

    // Asynchronous reset in the high phase of the clock
    load_reg(3, 8'h55);
    load_ac(8'h12);
    dp.bus_sel = SEL_W'(5);
    #1 chk("pre_rst_reg3", 32'(dp.bus), 32'h55);
    chk("pre_rst_ac", 32'(dp.ac), 32'h12);
    @(posedge CLK);
    #2 RST_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst_reg3", 32'(dp.bus), 32'h0);
    chk("async_rst_ac", 32'(dp.ac), 32'h0);
    chk("async_rst_z1", 32'(dp.z1), 32'd1);
    chk("async_rst_z2", 32'(dp.z2), 32'd1);
    chk("async_rst_stall", 32'(dp.stall), 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    set_idle();
    @(negedge CLK);

    // Increment with wrap, then write-priority cases
    load_reg(3, 8'hFE);
    dp.bus_sel = SEL_W'(5); dp.inc[3] = 1'b1;
    cycle();
    #1 chk("inc_ff", 32'(dp.bus), 32'hFF);
    cycle();
    #1 chk("inc_wrap", 32'(dp.bus), 32'h00);
    load_reg(3, 8'h33);
    dp.bus_sel = SEL_W'(5); dp.wen[3] = 1'b1; dp.inc[3] = 1'b1;
    cycle();
    #1 chk("wen_over_inc_self", 32'(dp.bus), 32'h33);
    dp.clr[3] = 1'b1;
    cycle();
    #1 chk("clr_priority", 32'(dp.bus), 32'h00);
    set_idle();
    check_outputs();

    // Memory wait stall
    load_reg(0, 8'h40);
    load_reg(5, 8'h66);
    dp.bus_sel = '0; dp.wen[5] = 1'b1; dp.inc[0] = 1'b1;
    dp.mem_valid = 1'b0; dp.mem_rdata = 8'h11; dp.ptr_sel = '0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall_on%0d", k), 32'(dp.stall), 32'd1);
      chk($sformatf("stall_reg0_%0d", k), 32'(dp.d_addr), 32'h40);
      cycle();
    end
    dp.bus_sel = SEL_W'(7);
    #1 chk("stall_reg5_held", 32'(dp.bus), 32'h66);
    dp.bus_sel = '0; dp.mem_valid = 1'b1; dp.mem_rdata = 8'hA7;
    #1 chk("stall_off", 32'(dp.stall), 32'd0);
    cycle();
    set_idle();
    dp.bus_sel = SEL_W'(7);
    #1 chk("mem_load_reg5", 32'(dp.bus), 32'hA7);
    chk("mem_inc_reg0", 32'(dp.d_addr), 32'h41);
    check_outputs();

    // Accumulator sweep
    load_reg(6, 8'h15);
    for (int op = 1; op <= 5; op++) begin
      load_ac(8'h0C);
      dp.bus_sel = SEL_W'(8); dp.alu_op = 3'(op); dp.ac_wen = 1'b1;
      cycle();
      set_idle();
      #1 chk($sformatf("alu_op%0d", op), 32'(dp.ac), alu_exp[op - 1]);
    end
    load_ac(8'hFF);
    dp.alu_op = 3'd6; dp.ac_wen = 1'b1;
    cycle();
    #1 chk("alu_inc_wrap", 32'(dp.ac), 32'h00);
    load_ac(8'h0C);
    dp.bus_sel = SEL_W'(1); dp.alu_op = 3'd1; dp.ac_wen = 1'b1;
    cycle();
    #1 chk("alu_self_add", 32'(dp.ac), 32'h18);
    set_idle();

    // Equality flags
    load_reg(10, 7);
    load_reg(11, 5);
    #1 chk("z2_a", 32'(dp.z2), 32'd0);
    dp.inc[11] = 1'b1;
    cycle();
    #1 chk("z2_b", 32'(dp.z2), 32'd0);
    cycle();
    set_idle();
    #1 chk("z2_c", 32'(dp.z2), 32'd1);
    chk("z1_before", 32'(dp.z1), 32'd1);
    load_reg(8, 3);
    #1 chk("z1_after", 32'(dp.z1), 32'd0);

    // Pointer mux
    for (int p = 0; p < PTR_N; p++) load_reg(p, 16 * (p + 1));
    for (int p = 0; p < PTR_N; p++) begin
      dp.ptr_sel = PSEL_W'(p);
      #1 chk($sformatf("ptr%0d", p), 32'(dp.d_addr), 32'(16 * (p + 1)));
    end
    @(negedge CLK);
    dp.ptr_sel = PSEL_W'(2); dp.inc[2] = 1'b1;
    cycle();
    dp.inc[2] = 1'b0;
    #1 chk("ptr_inc", 32'(dp.d_addr), 32'h31);
    @(negedge CLK);
    dump_check();

    // Random control traffic; inputs are held while the datapath is stalled
    held = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!held) begin
        for (int i = 0; i < NREG; i++) begin
          dp.wen[i] = ($urandom_range(0, 9) == 0);
          dp.inc[i] = ($urandom_range(0, 5) == 0);
          dp.clr[i] = ($urandom_range(0, 19) == 0);
        end
        dp.bus_sel = ($urandom_range(0, 3) == 0) ? '0 : SEL_W'($urandom_range(0, 15));
        dp.alu_op  = 3'($urandom_range(0, 7));
        dp.ac_wen  = 1'($urandom_range(0, 1));
        dp.ptr_sel = PSEL_W'($urandom_range(0, PTR_N - 1));
      end
      dp.mem_valid = ($urandom_range(0, 2) != 0);
      dp.mem_rdata = DATA_W'($urandom);
      check_outputs();
      held = m_stall();
      cycle();
      if (n % 100 == 99) dump_check();
    end
    dump_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
